// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter, LSB first, with load handshake and bit strobe
// Bit order matches the serial-in, MSB-entry, shift-right deserializer on the receive side.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             accept;

  // Ready also opens in the last-bit strobe cycle so frames can run back-to-back.
  assign load_ready = (state == IDLE) || ((state == SHIFT) && (cnt == LAST) && shift_en);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    cnt_d   = cnt;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = load_data;
      cnt_d   = '0;
    end else if ((state == SHIFT) && shift_en) begin
      shreg_d = {1'b0, shreg[WIDTH-1:1]};
      if (cnt == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
  end

  // Outputs are registered from the next-state values so they line up with shreg/cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      cnt        <= cnt_d;
      sout       <= (state_d == SHIFT) && shreg_d[0];
      sout_valid <= (state_d == SHIFT);
      sof        <= (state_d == SHIFT) && (cnt_d == '0);
      eof        <= (state_d == SHIFT) && (cnt_d == LAST);
      busy       <= (state_d == SHIFT);
    end
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out shift register with a valid/ready load handshake and a bit-rate enable. It converts WIDTH-bit words into an LSB-first serial stream whose bit order matches the team's serial-in, MSB-entry, shift-right deserializer. After WIDTH serial bits, that deserializer's parallel output equals the loaded word. The block sits at the transmit end of the on-board serial links, between a word source and the line driver.

## Interface
Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all logic uses the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_data  input  WIDTH  word to serialize; sampled on handshake.
- load_valid  input  1  source has a word on load_data.
- load_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  bit strobe; advances the stream by one bit when high.
- sout  output  1  serial data, LSB first.
- sout_valid  output  1  sout carries a frame bit.
- sof  output  1  high while sout carries bit 0 of a frame.
- eof  output  1  high while sout carries bit WIDTH-1 of a frame.
- busy  output  1  a frame is in progress (state SHIFT).

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: a frame is being sent.
- Shift register: WIDTH bits, shreg. Bit counter: cnt, $clog2(WIDTH) bits.
- Load handshake: a word is accepted on a rising edge where load_valid && load_ready. On acceptance:
  - shreg <= load_data
  - cnt <= 0
  - state <= SHIFT
- load_ready (combinational) = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1 && shift_en).
- In SHIFT:
  - sout = shreg[0]; sout_valid = 1.
  - sof = (cnt==0); eof = (cnt==WIDTH-1).
- shift_en high in SHIFT with cnt<WIDTH-1:
  - shreg <= {1'b0, shreg[WIDTH-1:1]}
  - cnt <= cnt+1
- shift_en high in SHIFT with cnt==WIDTH-1 (last bit consumed):
  - If a new word is accepted in the same cycle, it is loaded and the block stays in SHIFT (back-to-back, no gap bit).
  - Otherwise state <= IDLE.
- shift_en low: shreg, cnt and all outputs hold.
- IDLE: sout=0, sout_valid=0, sof=0, eof=0, busy=0. shift_en is ignored.
- load_valid during SHIFT, outside the last-bit cycle: not accepted. load_ready=0; the source holds the word.
- cnt never exceeds WIDTH-1; no wrap beyond the frame.

## Timing
- Reset values:
  - state=IDLE, shreg=0, cnt=0.
  - sout=0, sout_valid=0, sof=0, eof=0, busy=0, load_ready=1.
- Reset asserted mid-frame: the frame is aborted immediately (asynchronous) and the remaining bits are discarded. After release, the block is in IDLE with load_ready=1.
- Latency: a word accepted at edge N drives bit 0 on sout from just after edge N. That bit is held until the first edge with shift_en=1.
- Frame length: exactly WIDTH shift_en strobes. Minimum frame duration is WIDTH cycles when shift_en is tied high.
- Back-to-back with shift_en=1 continuously: sustained throughput is one word per WIDTH cycles, with sout_valid never dropping.
- All outputs are registered except load_ready, which is combinational from state, cnt and shift_en.

## Structure
- No shared package entries are needed. The state encoding (IDLE=1'b0, SHIFT=1'b1) is local to the module.
- Single module with no sub-modules. The counter and shift register are inline.
- The verification bench instantiates the existing deserializer (WIDTH=4) fed by sout, clocked only when shift_en && sout_valid, as a loopback checker.

## Test plan
- Reset: assert rst mid-frame after 2 bits of 4'hA -> sout_valid=0, busy=0, load_ready=1 immediately; the next frame starts clean.
- Single word, WIDTH=4, shift_en tied high: load 4'hB -> sout=1,1,0,1 on 4 consecutive cycles, sof on cycle 1 and eof on cycle 4; then IDLE; the loopback deserializer holds 4'hB.
- Back-to-back: load_valid held high with 4'h3 then 4'hC -> 8 contiguous valid bits 1,1,0,0,0,0,1,1; load_ready high only in IDLE and on each eof cycle.
- Stall: shift_en pulsed every 3rd cycle with word 4'h6 -> each bit held 3 cycles; the frame completes after 4 strobes; the output sequence is 0,1,1,0.
- Blocked load: load_valid asserted at bit 1 of a frame -> load_ready=0, no corruption; the word is accepted at eof and its bit 0 follows without a gap.
- WIDTH=8: load 8'h81 -> sout=1,0,0,0,0,0,0,1; cnt reaches 7 and returns to IDLE.
